truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper_if.sv | 25 ++
 rtl/truth_table_sweeper.sv | 112 +++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between a sweep requester and the truth-table sweeper.
// The requester (master) drives start and the DUT response; the sweeper (slave) drives stimulus and results.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_fail;
  logic            first_fail_vld;

  modport master (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_cnt, first_fail, first_fail_vld
  );

  modport slave (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_cnt, first_fail, first_fail_vld
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a combinational DUT in ascending order, holds each for HOLD
// cycles, and compares the response against the EXPECTED truth table at the last held cycle.
module truth_table_sweeper #(
  parameter int                  N_IN     = 4,
  parameter int                  HOLD     = 2,
  parameter logic [2**N_IN-1:0]  EXPECTED = 16'h8000
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [N_IN-1:0] V_LAST    = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [N_IN-1:0] r_dut_in, w_dut_in_nxt;
  logic [HCW-1:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [N_IN:0]   r_err_cnt, w_err_cnt_nxt;
  logic [N_IN-1:0] r_first_fail, w_first_fail_nxt;
  logic            r_first_fail_vld, w_first_fail_vld_nxt;

  logic w_sample;
  logic w_mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_dut_in         <= '0;
      r_hold_cnt       <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_fail     <= '0;
      r_first_fail_vld <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_dut_in         <= w_dut_in_nxt;
      r_hold_cnt       <= w_hold_cnt_nxt;
      r_busy           <= w_busy_nxt;
      r_done           <= w_done_nxt;
      r_err_cnt        <= w_err_cnt_nxt;
      r_first_fail     <= w_first_fail_nxt;
      r_first_fail_vld <= w_first_fail_vld_nxt;
    end
  end

  // dut_out only reaches state through the sample edge, never an output directly
  assign w_sample   = (r_state == RUN) && (r_hold_cnt == HOLD_LAST);
  assign w_mismatch = (bus.dut_out != EXPECTED[r_dut_in]);

  always_comb begin
    w_state_nxt          = r_state;
    w_dut_in_nxt         = r_dut_in;
    w_hold_cnt_nxt       = r_hold_cnt;
    w_busy_nxt           = r_busy;
    w_done_nxt           = r_done;
    w_err_cnt_nxt        = r_err_cnt;
    w_first_fail_nxt     = r_first_fail;
    w_first_fail_vld_nxt = r_first_fail_vld;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt          = RUN;
          w_dut_in_nxt         = '0;
          w_hold_cnt_nxt       = '0;
          w_busy_nxt           = 1'b1;
          w_done_nxt           = 1'b0;
          w_err_cnt_nxt        = '0;
          w_first_fail_nxt     = '0;
          w_first_fail_vld_nxt = 1'b0;
        end
      end
      RUN: begin
        if (w_sample) begin
          if (w_mismatch) begin
            w_err_cnt_nxt = r_err_cnt + (N_IN + 1)'(1);
            if (!r_first_fail_vld) begin
              w_first_fail_nxt     = r_dut_in;
              w_first_fail_vld_nxt = 1'b1;
            end
          end
          if (r_dut_in == V_LAST) begin
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_dut_in_nxt   = r_dut_in + N_IN'(1);
            w_hold_cnt_nxt = '0;
          end
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HCW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.dut_in         = r_dut_in;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_done && (r_err_cnt == '0);
  assign bus.err_cnt        = r_err_cnt;
  assign bus.first_fail     = r_first_fail;
  assign bus.first_fail_vld = r_first_fail_vld;

endmodule
